// File: rtl/branch_sequencer_pkg.sv
// Shared types and constants for the branch sequencer: states, opcode patterns,
// condition codes, control-word layout and the branch decoder (BL gated by BR_LINK_EN).
package branch_sequencer_pkg;

   localparam int CW_W = 33;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EVAL   = 2'd1,
      ST_LINK   = 2'd2,
      ST_UPDATE = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      BK_NONE  = 3'd0,
      BK_B     = 3'd1,
      BK_BL    = 3'd2,
      BK_CBZ   = 3'd3,
      BK_CBNZ  = 3'd4,
      BK_BCOND = 3'd5,
      BK_BR    = 3'd6
   } br_kind_t;

   localparam logic [5:0]  OP_B     = 6'b000101;
   localparam logic [5:0]  OP_BL    = 6'b100101;
   localparam logic [7:0]  OP_CBZ   = 8'b10110100;
   localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
   localparam logic [7:0]  OP_BCOND = 8'b01010100;
   localparam logic [21:0] OP_BR    = 22'b1101011000011111000000;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_HS = 4'h2;
   localparam logic [3:0] COND_LO = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;

   localparam logic [1:0] PC_FS_PASS = 2'b00;
   localparam logic [1:0] PC_FS_INC  = 2'b01;
   localparam logic [1:0] PC_FS_REL  = 2'b10;
   localparam logic [1:0] PC_FS_REG  = 2'b11;

   localparam logic [4:0] ALU_FS_OR  = 5'b00100;
   localparam logic [4:0] ALU_FS_NOP = 5'b11111;

   typedef struct packed {
      logic       alu_en;
      logic       alu_bs;
      logic [4:0] alu_fs;
      logic       rf_b_en;
      logic [4:0] rf_sa;
      logic [4:0] rf_sb;
      logic [4:0] rf_da;
      logic       rf_w;
      logic       ram_en;
      logic       ram_w;
      logic       pc_en;
      logic [1:0] pc_fs;
      logic       pc_is;
      logic       status_ld;
      logic [1:0] next_state;
   } cw_t;

   localparam cw_t CW_NOP = '{
      alu_en:     1'b0,
      alu_bs:     1'b0,
      alu_fs:     ALU_FS_NOP,
      rf_b_en:    1'b0,
      rf_sa:      5'd0,
      rf_sb:      5'd31,
      rf_da:      5'd0,
      rf_w:       1'b0,
      ram_en:     1'b0,
      ram_w:      1'b0,
      pc_en:      1'b0,
      pc_fs:      PC_FS_PASS,
      pc_is:      1'b0,
      status_ld:  1'b0,
      next_state: 2'b00
   };

   function automatic br_kind_t decode_branch(input logic [31:0] instr);
      br_kind_t kind;
      kind = BK_NONE;
      if (instr[31:26] == OP_B)
         kind = BK_B;
`ifdef BR_LINK_EN
      else if (instr[31:26] == OP_BL)
         kind = BK_BL;
`endif
      else if (instr[31:24] == OP_CBZ)
         kind = BK_CBZ;
      else if (instr[31:24] == OP_CBNZ)
         kind = BK_CBNZ;
      else if (instr[31:24] == OP_BCOND && !instr[4])
         kind = BK_BCOND;
      else if (instr[31:10] == OP_BR && instr[4:0] == 5'd0)
         kind = BK_BR;
      return kind;
   endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition-code evaluator: maps cond[3:0] and flags {V,C,N,Z}
// to a branch-taken decision.
module branch_cond_eval
   import branch_sequencer_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       taken
);

   logic v, c, n, z;

   assign {v, c, n, z} = flags;

   always_comb begin
      taken = 1'b1;
      case (cond)
         COND_EQ: taken = z;
         COND_NE: taken = !z;
         COND_HS: taken = c;
         COND_LO: taken = !c;
         COND_MI: taken = n;
         COND_PL: taken = !n;
         COND_VS: taken = v;
         COND_VC: taken = !v;
         COND_HI: taken = c & !z;
         COND_LS: taken = !(c & !z);
         COND_GE: taken = (n == v);
         COND_LT: taken = (n != v);
         COND_GT: taken = !z & (n == v);
         COND_LE: taken = !(!z & (n == v));
         default: taken = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_sequencer.sv
// Multi-cycle branch sequencer: IDLE -> EVAL -> [LINK] -> UPDATE control-word generator.
// Define BR_LINK_EN to support BL (link-register write); otherwise BL is treated as non-branch.
module branch_sequencer
   import branch_sequencer_pkg::*;
#(
   parameter int DATA_W   = 64,
   parameter int LINK_REG = 30
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       I,
   input  logic              instr_valid,
   input  logic [4:0]        status,
   output logic [CW_W-1:0]   cw,
   output logic [DATA_W-1:0] K,
   output logic              busy,
   output logic              done,
   output logic              taken
);

   localparam logic [4:0] LINK_RD = 5'(LINK_REG);

   state_t   state, state_nx;
   logic [31:0] instr_q, instr_nx;
   logic     taken_q, taken_nx;
   br_kind_t kind_in, kind_q;
   logic     cond_taken;
   cw_t      cw_s;
   logic signed [DATA_W-1:0] k_s;
   logic signed [DATA_W-1:0] off26, off19;

   assign kind_in = decode_branch(I);
   assign kind_q  = decode_branch(instr_q);

   assign off26 = {{(DATA_W-28){instr_q[25]}}, instr_q[25:0], 2'b00};
   assign off19 = {{(DATA_W-21){instr_q[23]}}, instr_q[23:5], 2'b00};

   branch_cond_eval u_cond (
      .cond  (instr_q[3:0]),
      .flags (status[3:0]),
      .taken (cond_taken)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         instr_q <= '0;
         taken_q <= 1'b0;
      end else begin
         state   <= state_nx;
         instr_q <= instr_nx;
         taken_q <= taken_nx;
      end
   end

   always_comb begin
      state_nx = state;
      instr_nx = instr_q;
      taken_nx = taken_q;
      cw_s     = CW_NOP;
      k_s      = '0;
      case (state)
         ST_IDLE: begin
            if (instr_valid && kind_in != BK_NONE) begin
               instr_nx = I;
               state_nx = ST_EVAL;
            end
         end
         ST_EVAL: begin
            case (kind_q)
               BK_CBZ, BK_CBNZ: begin
                  // Pass Rt through the ALU (A OR 0) so status[4] reflects Rt == 0
                  cw_s.rf_sa  = instr_q[4:0];
                  cw_s.alu_bs = 1'b1;
                  cw_s.alu_fs = ALU_FS_OR;
                  taken_nx    = (kind_q == BK_CBZ) ? status[4] : !status[4];
               end
               BK_BCOND: taken_nx = cond_taken;
               default:  taken_nx = 1'b1;
            endcase
            state_nx = ST_UPDATE;
`ifdef BR_LINK_EN
            if (kind_q == BK_BL)
               state_nx = ST_LINK;
`endif
         end
         ST_LINK: begin
            // PC unit presents the held PC+4 which the register file captures
            cw_s.pc_en = 1'b1;
            cw_s.pc_fs = PC_FS_PASS;
            cw_s.rf_da = LINK_RD;
            cw_s.rf_w  = 1'b1;
            state_nx   = ST_UPDATE;
         end
         ST_UPDATE: begin
            state_nx = ST_IDLE;
            if (kind_q == BK_BR) begin
               cw_s.rf_sa = instr_q[9:5];
               cw_s.pc_fs = PC_FS_REG;
               cw_s.pc_is = 1'b1;
            end else if (taken_q) begin
               cw_s.pc_fs = PC_FS_REL;
               k_s = (kind_q == BK_B || kind_q == BK_BL) ? off26 : off19;
            end else begin
               cw_s.pc_fs = PC_FS_INC;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign cw    = cw_s;
   assign K     = k_s;
   assign busy  = (state != ST_IDLE);
   assign done  = (state == ST_UPDATE);
   assign taken = taken_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed, table-driven bench for branch_sequencer with hand-computed control words.
module tb_branch_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] I;
   logic        instr_valid;
   logic [4:0]  status;
   logic [32:0] cw;
   logic [63:0] K;
   logic        busy, done, taken;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   branch_sequencer dut (
      .clock       (clock),
      .reset       (reset),
      .I           (I),
      .instr_valid (instr_valid),
      .status      (status),
      .cw          (cw),
      .K           (K),
      .busy        (busy),
      .done        (done),
      .taken       (taken)
   );

   typedef struct packed {
      logic [31:0] instr;
      logic [4:0]  st;
      logic [32:0] eval_cw;
      logic        tk;
      logic [32:0] upd_cw;
      logic [63:0] k;
   } vec_t;

   vec_t vecs [0:31];
   int   nv = 0;

   function automatic logic [32:0] mk_cw(input logic [4:0] fs, input logic bs,
                                         input logic [4:0] sa, input logic [4:0] da,
                                         input logic w, input logic pen,
                                         input logic [1:0] pfs, input logic pis);
      logic [32:0] c;
      c        = '0;
      c[31]    = bs;
      c[30:26] = fs;
      c[24:20] = sa;
      c[19:15] = 5'd31;
      c[14:10] = da;
      c[9]     = w;
      c[6]     = pen;
      c[5:4]   = pfs;
      c[3]     = pis;
      return c;
   endfunction

   logic [32:0] nop_cw, rel_cw, inc_cw;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic [31:0] i, input logic [4:0] st, input logic [32:0] ecw,
                      input logic tk, input logic [32:0] ucw, input logic [63:0] k);
      vecs[nv].instr   = i;
      vecs[nv].st      = st;
      vecs[nv].eval_cw = ecw;
      vecs[nv].tk      = tk;
      vecs[nv].upd_cw  = ucw;
      vecs[nv].k       = k;
      nv++;
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      v = vecs[idx];
      @(posedge clock); #1;
      I = v.instr; instr_valid = 1'b1; status = 5'h00;
      @(negedge clock);
      chk($sformatf("v%0d.accept_busy", idx), 64'(busy), 64'd0);
      chk($sformatf("v%0d.accept_cw", idx), 64'(cw), 64'(nop_cw));
      @(posedge clock); #1;
      // a competing branch offered while busy must be ignored
      I = 32'h1400_0001; instr_valid = 1'b1; status = v.st;
      @(negedge clock);
      chk($sformatf("v%0d.eval_busy", idx), 64'(busy), 64'd1);
      chk($sformatf("v%0d.eval_done", idx), 64'(done), 64'd0);
      chk($sformatf("v%0d.eval_cw", idx), 64'(cw), 64'(v.eval_cw));
      chk($sformatf("v%0d.eval_k", idx), K, 64'd0);
      @(posedge clock); #1;
      status = 5'h00;
      @(negedge clock);
      chk($sformatf("v%0d.upd_done", idx), 64'(done), 64'd1);
      chk($sformatf("v%0d.upd_taken", idx), 64'(taken), 64'(v.tk));
      chk($sformatf("v%0d.upd_cw", idx), 64'(cw), 64'(v.upd_cw));
      chk($sformatf("v%0d.upd_k", idx), K, v.k);
      @(posedge clock); #1;
      instr_valid = 1'b0;
      @(negedge clock);
      chk($sformatf("v%0d.after_busy", idx), 64'(busy), 64'd0);
      chk($sformatf("v%0d.after_done", idx), 64'(done), 64'd0);
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, ".busy"}, 64'(busy), 64'd0);
      chk({nm, ".done"}, 64'(done), 64'd0);
      chk({nm, ".taken"}, 64'(taken), 64'd0);
      chk({nm, ".cw"}, 64'(cw), 64'(nop_cw));
      chk({nm, ".k"}, K, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [31:0] nonbr [4];
   logic [3:0]  bc_flags [16];
   logic        bc_exp [16];

   initial begin
      nop_cw = mk_cw(5'h1F, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0);
      rel_cw = mk_cw(5'h1F, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b10, 1'b0);
      inc_cw = mk_cw(5'h1F, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0);

      add(32'h17FF_FFFF, 5'h00, nop_cw, 1'b1, rel_cw, 64'hFFFF_FFFF_FFFF_FFFC);
      add(32'h1400_0003, 5'h00, nop_cw, 1'b1, rel_cw, 64'd12);
      add(32'hB400_0102, 5'h10, mk_cw(5'b00100, 1'b1, 5'd2, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0),
          1'b1, rel_cw, 64'd32);
      add(32'hB400_0102, 5'h0F, mk_cw(5'b00100, 1'b1, 5'd2, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0),
          1'b0, inc_cw, 64'd0);
      add(32'hB500_0105, 5'h10, mk_cw(5'b00100, 1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0),
          1'b0, inc_cw, 64'd0);
      add(32'hB500_0105, 5'h00, mk_cw(5'b00100, 1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0),
          1'b1, rel_cw, 64'd32);
      add(32'hB4FF_FFC0, 5'h10, mk_cw(5'b00100, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0),
          1'b1, rel_cw, 64'hFFFF_FFFF_FFFF_FFF8);
      add(32'hD61F_00E0, 5'h00, nop_cw, 1'b1,
          mk_cw(5'h1F, 1'b0, 5'd7, 5'd0, 1'b0, 1'b0, 2'b11, 1'b1), 64'd0);

      bc_flags = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0010, 4'b0000, 4'b0000, 4'b1000,
                   4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b1010, 4'b1010, 4'b0000, 4'b1111};
      bc_exp   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int c = 0; c < 16; c++) begin
         add(32'h5400_0060 | 32'(c), {c[0], bc_flags[c]}, nop_cw, bc_exp[c],
             bc_exp[c] ? rel_cw : inc_cw, bc_exp[c] ? 64'd12 : 64'd0);
      end
      add(32'h5400_006C, 5'h0B, nop_cw, 1'b0, inc_cw, 64'd0);
      add(32'h5400_0068, 5'h05, nop_cw, 1'b0, inc_cw, 64'd0);
      add(32'h5400_006A, 5'h0A, nop_cw, 1'b1, rel_cw, 64'd12);

      reset = 1'b1; I = 32'h1400_0003; instr_valid = 1'b1; status = 5'h00;
      #2;
      check_reset_outputs("por");
      repeat (2) @(posedge clock);
      #1;
      chk("por_hold.busy", 64'(busy), 64'd0);
      reset = 1'b0; instr_valid = 1'b0;

      for (int n = 0; n < nv; n++) run_vec(n);

      nonbr = '{32'h8B00_0000, 32'h5400_0030, 32'hD61F_00E1, 32'hD63F_0000};
      for (int n = 0; n < 4; n++) begin
         @(posedge clock); #1;
         I = nonbr[n]; instr_valid = 1'b1;
         @(posedge clock); #1;
         instr_valid = 1'b0;
         @(negedge clock);
         chk($sformatf("nonbranch%0d.busy", n), 64'(busy), 64'd0);
      end

      @(posedge clock); #1;
      I = 32'h1400_0003; instr_valid = 1'b0;
      @(posedge clock); #1;
      @(negedge clock);
      chk("novalid.busy", 64'(busy), 64'd0);

`ifdef BR_LINK_EN
      @(posedge clock); #1;
      I = 32'h9400_0004; instr_valid = 1'b1;
      @(posedge clock); #1;
      instr_valid = 1'b0;
      @(negedge clock);
      chk("bl.eval_busy", 64'(busy), 64'd1);
      chk("bl.eval_cw", 64'(cw), 64'(nop_cw));
      @(posedge clock); #1;
      @(negedge clock);
      chk("bl.link_done", 64'(done), 64'd0);
      chk("bl.link_cw", 64'(cw), 64'(mk_cw(5'h1F, 1'b0, 5'd0, 5'd30, 1'b1, 1'b1, 2'b00, 1'b0)));
      @(posedge clock); #1;
      @(negedge clock);
      chk("bl.upd_done", 64'(done), 64'd1);
      chk("bl.upd_taken", 64'(taken), 64'd1);
      chk("bl.upd_cw", 64'(cw), 64'(rel_cw));
      chk("bl.upd_k", K, 64'd16);
      @(posedge clock); #1;
      @(negedge clock);
      chk("bl.after_busy", 64'(busy), 64'd0);

      @(posedge clock); #1;
      I = 32'h9400_0004; instr_valid = 1'b1;
      @(posedge clock); #1;
      instr_valid = 1'b0;
      @(posedge clock); #1;
      @(negedge clock);
      chk("bl_rst.link_rfw", 64'(cw[9]), 64'd1);
      #1 reset = 1'b1;
      #1;
      chk("bl_rst.rfw", 64'(cw[9]), 64'd0);
      check_reset_outputs("bl_rst");
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("bl_rst.after_busy", 64'(busy), 64'd0);
`else
      @(posedge clock); #1;
      I = 32'h9400_0004; instr_valid = 1'b1;
      @(negedge clock);
      chk("bl_off.accept_busy", 64'(busy), 64'd0);
      @(posedge clock); #1;
      instr_valid = 1'b0;
      @(negedge clock);
      chk("bl_off.busy", 64'(busy), 64'd0);
      @(posedge clock); #1;
      @(negedge clock);
      chk("bl_off.busy2", 64'(busy), 64'd0);
`endif

      @(posedge clock); #1;
      I = 32'h1400_0003; instr_valid = 1'b1;
      @(posedge clock); #1;
      instr_valid = 1'b0;
      @(posedge clock); #1;
      @(negedge clock);
      chk("upd_rst.done_before", 64'(done), 64'd1);
      chk("upd_rst.taken_before", 64'(taken), 64'd1);
      #1 reset = 1'b1;
      #1;
      check_reset_outputs("upd_rst");
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("upd_rst.after_busy", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
